mdu_seq_multiplier: RTL

//  Iterative RV32M multiplier (MUL, MULH, MULHSU, MULHU) in the MDU, downstream of decode/issue.

---
 rtl/mdu_seq_multiplier.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mdu_seq_multiplier.sv
// -----------------------------------------------------------------------------
// mdu_seq_multiplier
//   Iterative RV32M multiplier (MUL, MULH, MULHSU, MULHU). Operands are
//   converted to unsigned magnitudes on accept, multiplied by shift-and-add
//   BITS_PER_CYCLE multiplier bits per CALC cycle, then sign-corrected and
//   the requested half is registered into result.
//
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   in_valid   operation presented by execute
//   in_ready   block can accept (IDLE only)
//   op         funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1, rs2   multiplicand / multiplier
//   flush      aborts any in-flight operation, blocks acceptance in IDLE
//   out_valid  result available, held until consumed
//   out_ready  downstream accepts result
//   result     low half (MUL) or high half (others) of the product
// -----------------------------------------------------------------------------
module mdu_seq_multiplier #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int unsigned STEPS = XLEN / BITS_PER_CYCLE;
   localparam int unsigned CW    = $clog2(STEPS + 1);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [XLEN-1:0]     mcand_q, mcand_d;
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [CW-1:0]       count_q, count_d;
   logic                neg_q, neg_d;
   logic [1:0]          op_q, op_d;

   logic                rs1_neg, rs2_neg;
   logic [2*XLEN-1:0]   partial;
   logic [2*XLEN-1:0]   acc_next;
   logic [2*XLEN-1:0]   prod;
   logic [31:0]         shamt;

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      count_d     = count_q;
      neg_d       = neg_q;
      op_d        = op_q;

      // rs1 is signed for MULH/MULHSU, rs2 only for MULH
      rs1_neg = ((op == 2'b01) || (op == 2'b10)) && rs1[XLEN-1];
      rs2_neg = (op == 2'b01) && rs2[XLEN-1];

      shamt    = 32'(count_q) * 32'(BITS_PER_CYCLE);
      partial  = (2*XLEN)'(mcand_q) * (2*XLEN)'(mplier_q[BITS_PER_CYCLE-1:0]);
      acc_next = acc_q + (partial << shamt);
      prod     = neg_q ? (~acc_q + 1'b1) : acc_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && !flush) begin
               op_d     = op;
               mcand_d  = rs1_neg ? (~rs1 + 1'b1) : rs1;
               mplier_d = rs2_neg ? (~rs2 + 1'b1) : rs2;
               neg_d    = rs1_neg ^ rs2_neg;
               acc_d    = '0;
               count_d  = '0;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d    = acc_next;
               mplier_d = mplier_q >> BITS_PER_CYCLE;
               count_d  = count_q + 1'b1;
               if (count_q == LAST) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // First DONE cycle performs sign correction and half select;
            // result is presented from the following cycle onward.
            if (flush) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end else if (!out_valid_q) begin
               result_d    = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      in_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         count_q     <= '0;
         neg_q       <= 1'b0;
         op_q        <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         neg_q       <= neg_d;
         op_q        <= op_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule
